// File: rtl/ascii_uart_tx.sv
// 8N1 UART transmitter with a small character FIFO in front of it.
// Characters enter through a valid/ready strobe and go out LSB first on tx.
module ascii_uart_tx #(
    parameter int CLKS_PER_BIT = 868,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [7:0]                    data_in,
    input  logic                          data_valid,
    output logic                          data_ready,
    output logic                          tx,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] BAUD_MAX = CW'(CLKS_PER_BIT - 1);
    localparam logic [AW:0]   FULL     = (AW + 1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t          state, state_next;
    logic [7:0]      mem [FIFO_DEPTH];
    logic [AW-1:0]   wr_ptr, rd_ptr;
    logic [AW:0]     count;
    logic [CW-1:0]   baud, baud_next;
    logic [2:0]      bit_idx, bit_next;
    logic [7:0]      shift, shift_next;
    logic            tx_next;
    logic            push, pop;
    logic            fifo_empty, baud_end;

    assign data_ready = (count != FULL);
    assign push       = data_valid && data_ready;
    assign fifo_empty = (count == '0);
    assign baud_end   = (baud == BAUD_MAX);
    assign fifo_count = count;
    assign busy       = (state != IDLE);

    // Storage holds data only, so it carries no reset.
    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= data_in;
    end

    // Pointers wrap naturally because the depth is a power of two.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_comb begin
        state_next = state;
        baud_next  = baud;
        bit_next   = bit_idx;
        shift_next = shift;
        pop        = 1'b0;
        case (state)
            IDLE: begin
                if (!fifo_empty) begin
                    pop        = 1'b1;
                    shift_next = mem[rd_ptr];
                    baud_next  = '0;
                    state_next = START;
                end
            end
            START: begin
                if (baud_end) begin
                    baud_next  = '0;
                    bit_next   = 3'd0;
                    state_next = DATA;
                end else begin
                    baud_next = baud + 1'b1;
                end
            end
            DATA: begin
                if (baud_end) begin
                    baud_next  = '0;
                    shift_next = {1'b0, shift[7:1]};
                    if (bit_idx == 3'd7)
                        state_next = STOP;
                    else
                        bit_next = bit_idx + 3'd1;
                end else begin
                    baud_next = baud + 1'b1;
                end
            end
            STOP: begin
                if (baud_end) begin
                    baud_next = '0;
                    if (!fifo_empty) begin
                        pop        = 1'b1;
                        shift_next = mem[rd_ptr];
                        state_next = START;
                    end else begin
                        state_next = IDLE;
                    end
                end else begin
                    baud_next = baud + 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase

        // Line level follows the state being entered so tx stays a plain register.
        case (state_next)
            START:   tx_next = 1'b0;
            DATA:    tx_next = shift_next[0];
            default: tx_next = 1'b1;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            baud    <= '0;
            bit_idx <= 3'd0;
            tx      <= 1'b1;
        end else begin
            state   <= state_next;
            baud    <= baud_next;
            bit_idx <= bit_next;
            tx      <= tx_next;
        end
    end

    always_ff @(posedge clk) begin
        shift <= shift_next;
    end

endmodule

// File: tb/tb_ascii_uart_tx.sv
// Directed bench for ascii_uart_tx at 4 clocks per bit and a 4-deep FIFO.
// A background line monitor decodes frames; the main thread compares them.
module tb_ascii_uart_tx;

    localparam int CPB   = 4;
    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [7:0] data_in = 8'h00;
    logic       data_valid = 1'b0;
    logic       data_ready;
    logic       tx;
    logic       busy;
    logic [2:0] fifo_count;

    int n_chk  = 0;
    int n_pass = 0;
    int cyc    = 0;
    int busy_cnt = 0;
    int max_cnt  = 0;
    int rd_idx   = 0;

    logic [7:0]  rx_q [$];
    logic [39:0] raw_q [$];
    bit          good_q [$];
    int          st_q [$];
    logic [7:0]  exp_q [$];

    ascii_uart_tx #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .data_in    (data_in),
        .data_valid (data_valid),
        .data_ready (data_ready),
        .tx         (tx),
        .busy       (busy),
        .fifo_count (fifo_count)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (busy === 1'b1)
            busy_cnt <= busy_cnt + 1;
        if (rst === 1'b0 && fifo_count !== 3'bxxx && int'(fifo_count) > max_cnt)
            max_cnt <= int'(fifo_count);
    end

    // Line monitor: 40 samples per frame, one per clock, from the first low cycle.
    initial begin
        logic [39:0] raw;
        logic [7:0]  b;
        bit          good;
        int          st;
        forever begin
            @(negedge clk);
            if (tx === 1'b0 && rst === 1'b0) begin
                st = cyc;
                raw = '0;
                raw[0] = tx;
                for (int i = 1; i < 40; i++) begin
                    @(negedge clk);
                    raw[i] = tx;
                end
                good = 1'b1;
                for (int j = 0; j < 10; j++)
                    for (int k = 1; k < CPB; k++)
                        if (raw[CPB*j+k] !== raw[CPB*j]) good = 1'b0;
                if (raw[0] !== 1'b0) good = 1'b0;
                if (raw[36] !== 1'b1) good = 1'b0;
                for (int j = 0; j < 8; j++)
                    b[j] = raw[CPB*(j+1)];
                rx_q.push_back(b);
                raw_q.push_back(raw);
                good_q.push_back(good);
                st_q.push_back(st);
            end
        end
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp)
            n_pass++;
        else
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle(input string tag);
        for (int k = 0; k < 3000; k++) begin
            @(negedge clk);
            if (busy === 1'b0) break;
        end
        chk({tag, "_idle"}, busy, 1'b0);
    endtask

    // Compare every queued expectation against monitor frames, oldest first.
    task automatic check_frames(input string tag);
        int first;
        first = rd_idx;
        for (int i = 0; i < exp_q.size(); i++) begin
            if (rd_idx < rx_q.size()) begin
                chk($sformatf("%s_byte%0d", tag, i), rx_q[rd_idx], exp_q[i]);
                chk($sformatf("%s_fmt%0d", tag, i), good_q[rd_idx], 1'b1);
                if (i > 0)
                    chk($sformatf("%s_gap%0d", tag, i), st_q[rd_idx] - st_q[rd_idx-1], 40);
                rd_idx++;
            end else begin
                chk($sformatf("%s_missing%0d", tag, i), rx_q.size() - first, exp_q.size());
            end
        end
        chk({tag, "_extra"}, rx_q.size() - first, exp_q.size());
    endtask

    initial begin
        logic [9:0]  lv;
        logic [39:0] exp_raw;
        int          n;
        int          base;
        int          bad;
        logic [7:0]  burst [5];
        logic [7:0]  wrap [10];

        // Async reset between edges, no clock edge needed.
        #13;
        rst = 1'b1;
        #1;
        chk("rst_tx", tx, 1'b1);
        chk("rst_busy", busy, 1'b0);
        chk("rst_count", fifo_count, 3'd0);
        chk("rst_ready", data_ready, 1'b1);
        tick();
        tick();
        rst = 1'b0;
        tick();

        // Single '1' frame.
        data_in = 8'h31;
        data_valid = 1'b1;
        tick();
        data_valid = 1'b0;
        @(negedge clk);
        chk("one_count_acc", fifo_count, 3'd1);
        chk("one_tx_acc", tx, 1'b1);
        chk("one_busy_acc", busy, 1'b0);
        @(negedge clk);
        chk("one_tx_start", tx, 1'b0);
        chk("one_busy_start", busy, 1'b1);
        chk("one_count_pop", fifo_count, 3'd0);
        n = 1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (busy === 1'b1) n++;
            else break;
        end
        chk("one_busy_len", n, 40);
        lv = 10'b1001100010;
        for (int j = 0; j < 10; j++)
            for (int k = 0; k < CPB; k++)
                exp_raw[CPB*j+k] = lv[j];
        if (rd_idx < raw_q.size())
            chk("one_line", raw_q[rd_idx], exp_raw);
        else
            chk("one_line_missing", raw_q.size(), rd_idx + 1);
        exp_q = '{8'h31};
        check_frames("one");

        // Burst to full, then a refused write.
        burst = '{8'h41, 8'h42, 8'h43, 8'h44, 8'h45};
        base = busy_cnt;
        tick();
        for (int i = 0; i < 5; i++) begin
            data_in = burst[i];
            data_valid = 1'b1;
            tick();
        end
        chk("burst_ready_full", data_ready, 1'b0);
        chk("burst_count_full", fifo_count, 3'd4);
        data_in = 8'h0D;
        tick();
        data_valid = 1'b0;
        chk("burst_count_refused", fifo_count, 3'd4);
        wait_idle("burst");
        chk("burst_busy_len", busy_cnt - base, 200);
        exp_q = '{8'h41, 8'h42, 8'h43, 8'h44, 8'h45};
        check_frames("burst");

        // Write lands on the same edge a STOP ends and pops.
        tick();
        data_in = 8'h50;
        data_valid = 1'b1;
        tick();
        data_in = 8'h51;
        tick();
        data_valid = 1'b0;
        chk("sim_count_pre", fifo_count, 3'd1);
        repeat (39) tick();
        chk("sim_tx_stop", tx, 1'b1);
        data_in = 8'h52;
        data_valid = 1'b1;
        tick();
        data_valid = 1'b0;
        chk("sim_count_same", fifo_count, 3'd1);
        chk("sim_tx_next_start", tx, 1'b0);
        wait_idle("sim");
        exp_q = '{8'h50, 8'h51, 8'h52};
        check_frames("sim");

        // Reset during data bit 3 of 8'h2B with two characters queued.
        tick();
        data_in = 8'h2B;
        data_valid = 1'b1;
        tick();
        data_in = 8'h41;
        tick();
        data_in = 8'h42;
        tick();
        data_valid = 1'b0;
        chk("mid_count_q", fifo_count, 3'd2);
        repeat (15) tick();
        chk("mid_bit3", tx, 1'b1);
        chk("mid_busy_pre", busy, 1'b1);
        #2;
        rst = 1'b1;
        #1;
        chk("mid_rst_tx", tx, 1'b1);
        chk("mid_rst_count", fifo_count, 3'd0);
        chk("mid_rst_busy", busy, 1'b0);
        tick();
        rst = 1'b0;
        bad = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (tx !== 1'b1 || busy !== 1'b0 || fifo_count !== 3'd0) bad++;
        end
        chk("mid_quiet", bad, 0);
        rd_idx = rx_q.size();

        // Ten characters with random valid gaps across pointer wrap.
        wrap = '{8'h61, 8'h62, 8'h63, 8'h64, 8'h65, 8'h31, 8'h32, 8'h33, 8'h34, 8'h35};
        tick();
        for (int i = 0; i < 10; i++) begin
            repeat ($urandom_range(0, 3)) tick();
            data_in = wrap[i];
            data_valid = 1'b1;
            for (int w = 0; w < 400 && data_ready !== 1'b1; w++)
                tick();
            chk($sformatf("wrap_ready%0d", i), data_ready, 1'b1);
            tick();
            data_valid = 1'b0;
        end
        wait_idle("wrap");
        chk("wrap_max_count", (max_cnt <= DEPTH), 1'b1);
        exp_q = '{8'h61, 8'h62, 8'h63, 8'h64, 8'h65, 8'h31, 8'h32, 8'h33, 8'h34, 8'h35};
        for (int i = 0; i < 10; i++) begin
            if (rd_idx < rx_q.size()) begin
                chk($sformatf("wrap_byte%0d", i), rx_q[rd_idx], exp_q[i]);
                chk($sformatf("wrap_fmt%0d", i), good_q[rd_idx], 1'b1);
                rd_idx++;
            end else begin
                chk($sformatf("wrap_missing%0d", i), rx_q.size(), rd_idx + 1);
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
